nf_router_ctrl: RTL and testbench
=================================

// Module: nf_router_ctrl
// PURPOSE
//  Load/store bus controller between the core data port and Slave_n slaves.
//  - Decodes the master address against a fixed map.
//  - Issues a per-slave request, waits for the slave ack, then completes the master transfer.
//  - Holds a one-hot read-select for the read-data mux.
//  - Reports unmapped addresses and slave timeouts as errors.
//  - Sits between the core LSU and the peripheral/RAM slaves; drives the read-data mux select.
// PARAMETERS
//  Slave_n   `slave_number (4)  number of slaves, one-hot select width
//  TIMEOUT   15                 max cycles waiting for ack_s; 0 = wait forever
// PORTS
//  clk       in   1              system clock, all state on posedge
//  resetn    in   1              asynchronous active-low reset
//  addr_m    in   32             master address
//  we_m      in   1              master write enable (1 = sw, 0 = lw)
//  req_m     in   1              master request, sampled only in IDLE
//  ack_m     out  1              one-cycle transfer-complete pulse (ok or error)
//  err_m     out  1              one-cycle error pulse, coincident with ack_m
//  req_s     out  Slave_n        one-hot slave request, held until ack or timeout
//  we_s      out  1              registered copy of we_m, valid while req_s != 0
//  addr_s    out  32             registered copy of addr_m, valid while req_s != 0
//  ack_s     in   Slave_n        per-slave acknowledge
//  rd_sel    out  Slave_n        one-hot read-mux select, stable between transfers
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, ack_m=0, err_m=0, req_s=0, we_s=0, addr_s=0,
//   rd_sel='b1 (slave 0), counter=0. Reset mid-transfer aborts with no ack_m.
//  FSM states IDLE, ACCESS, RESP, ERR. All outputs are registered.
//  IDLE: if req_m=1 at an edge, decode addr_m.
//   - No hit -> ERR.
//   - Hit -> latch addr_s/we_s, set req_s=rd_sel=hit one-hot, counter=0 -> ACCESS.
//   - Multiple hits: lowest index wins.
//  ACCESS: req_s held, counter+1 per cycle (saturating at TIMEOUT).
//   - ack_s[sel]=1 -> req_s=0 -> RESP.
//   - Else if TIMEOUT!=0 and counter==TIMEOUT-1 -> req_s=0 -> ERR.
//   - ack on the same edge as the timeout: ack wins.
//   - ack_s bits of non-selected slaves are ignored.
//   - req_m/addr_m changes are ignored until back in IDLE; req_m dropping does not abort.
//  RESP: ack_m=1, err_m=0 for one cycle -> IDLE.
//  ERR: ack_m=1, err_m=1 for one cycle -> IDLE.
//   - rd_sel: unmapped access keeps its previous value; timeout keeps the timed-out slave.
//  Latency: req_m sampled at edge 0; req_s high from edge 0.
//   - ack_s seen at edge k -> ack_m high cycle after edge k+1 -> IDLE.
//   - Back-to-back minimum: 3 cycles per transfer.
//   - req_m held high re-issues a new transfer from IDLE.
//  rd_sel changes only when entering ACCESS; the read mux output is valid while ack_m=1.
//  Counter width: $clog2(TIMEOUT+1), minimum 1 bit.
// STRUCTURE
//  nf_router_pkg: state enum, address map.
//   - NF_SLAVE_BASE[Slave_n], NF_SLAVE_MASK[Slave_n] (32-bit each).
//   - Map: 0 RAM 0x0000_0000/0xFFFF_0000, 1 GPIO 0x0001_0000/0xFFFF_FF00,
//     2 PWM 0x0002_0000/0xFFFF_FF00, 3 UART 0x0003_0000/0xFFFF_FF00.
//  Sub-module nf_router_dec: combinational decoder.
//   - Hit i = (addr & MASK[i]) == BASE[i]; output is the lowest-index one-hot plus a hit flag.
//  FSM, counter and output registers live in nf_router_ctrl.
// TESTING
//  1 Reset with resetn=0 mid-ACCESS -> all outputs 0, rd_sel=4'b0001, no ack_m after release.
//  2 lw 0x0001_0004; GPIO ack_s=4'b0010 two cycles later:
//    -> req_s=4'b0010, we_s=0, rd_sel=4'b0010; ack_m one pulse, err_m=0.
//  3 sw 0x0000_1000; RAM acks the same cycle req_s rises:
//    -> ack_m at the 3rd cycle after req_m; back-to-back second sw also takes 3 cycles.
//  4 lw 0x0005_0000 (unmapped) -> no req_s; ack_m=err_m=1 one cycle; rd_sel unchanged.
//  5 sw 0x0002_0000, PWM never acks, TIMEOUT=15:
//    -> req_s drops after 15 cycles; ack_m=err_m=1 once; then an access to slave 0 succeeds.
//  6 During ACCESS to slave 3, ack_s=4'b0001 and req_m toggles -> ignored; completes only on ack_s[3].

Source files
------------

// File: rtl/nf_router_pkg.sv
// Shared definitions for the load/store router: FSM encoding and the fixed slave address map.
package nf_router_pkg;

    localparam int NF_SLAVE_N = 4;

    typedef logic [1:0] nf_state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [1:0] ST_ERR    = 2'd3;

    // Element i is slave i: 0 RAM, 1 GPIO, 2 PWM, 3 UART.
    localparam logic [NF_SLAVE_N-1:0][31:0] NF_SLAVE_BASE = {
        32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000
    };
    localparam logic [NF_SLAVE_N-1:0][31:0] NF_SLAVE_MASK = {
        32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_0000
    };

endpackage

// File: rtl/nf_router_dec.sv
// Combinational address decoder: lowest-index matching slave as a one-hot select plus a hit flag.
module nf_router_dec
    import nf_router_pkg::*;
#(
    parameter int Slave_n = NF_SLAVE_N
) (
    input  logic [31:0]        addr,
    output logic [Slave_n-1:0] sel,
    output logic               hit
);

    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < Slave_n; i++) begin
            if (!hit && ((addr & NF_SLAVE_MASK[i]) == NF_SLAVE_BASE[i])) begin
                sel[i] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nf_router_ctrl.sv
// Load/store bus controller: decodes the core address, requests one slave, waits for its ack
// (bounded by TIMEOUT) and completes the master transfer with a one-cycle ack_m/err_m pulse.
module nf_router_ctrl
    import nf_router_pkg::*;
#(
    parameter int Slave_n = NF_SLAVE_N,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [31:0]        addr_m,
    input  logic               we_m,
    input  logic               req_m,
    output logic               ack_m,
    output logic               err_m,
    output logic [Slave_n-1:0] req_s,
    output logic               we_s,
    output logic [31:0]        addr_s,
    input  logic [Slave_n-1:0] ack_s,
    output logic [Slave_n-1:0] rd_sel,
    output nf_state_t          dbg_state
);

    localparam int CNT_W = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    nf_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic [Slave_n-1:0] dec_sel;
    logic               dec_hit;
    logic               sel_ack;

    nf_router_dec #(.Slave_n(Slave_n)) u_dec (
        .addr (addr_m),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    // Slave handshake: req_s is a one-hot valid held until the selected slave raises its
    // ack_s bit (or the timeout fires); acks from any other slave are ignored.
    assign sel_ack   = |(ack_s & req_s);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            ack_m  <= 1'b0;
            err_m  <= 1'b0;
            req_s  <= '0;
            we_s   <= 1'b0;
            addr_s <= '0;
            rd_sel <= Slave_n'(1);
            cnt    <= '0;
        end else begin
            ack_m <= 1'b0;
            err_m <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_m) begin
                        if (dec_hit) begin
                            addr_s <= addr_m;
                            we_s   <= we_m;
                            req_s  <= dec_sel;
                            rd_sel <= dec_sel;
                            cnt    <= '0;
                            state  <= ST_ACCESS;
                        end else begin
                            state <= ST_ERR;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (sel_ack) begin
                        req_s <= '0;
                        state <= ST_RESP;
                    end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                        req_s <= '0;
                        state <= ST_ERR;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    ack_m <= 1'b1;
                    state <= ST_IDLE;
                end
                ST_ERR: begin
                    ack_m <= 1'b1;
                    err_m <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nf_router_ctrl.sv
// Directed testbench for nf_router_ctrl: reset abort, normal/back-to-back transfers,
// unmapped access, slave timeout and foreign-ack/req_m interference.
module tb_nf_router_ctrl;

    logic        clk;
    logic        resetn;
    logic [31:0] addr_m;
    logic        we_m;
    logic        req_m;
    logic        ack_m;
    logic        err_m;
    logic [3:0]  req_s;
    logic        we_s;
    logic [31:0] addr_s;
    logic [3:0]  ack_s;
    logic [3:0]  rd_sel;
    logic [1:0]  dbg_state;

    int tests;
    int failed;

    nf_router_ctrl #(.Slave_n(4), .TIMEOUT(15)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .addr_m    (addr_m),
        .we_m      (we_m),
        .req_m     (req_m),
        .ack_m     (ack_m),
        .err_m     (err_m),
        .req_s     (req_s),
        .we_s      (we_s),
        .addr_s    (addr_s),
        .ack_s     (ack_s),
        .rd_sel    (rd_sel),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are then stable for checking and driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        resetn = 1'b0;
        addr_m = '0;
        we_m   = 1'b0;
        req_m  = 1'b0;
        ack_s  = '0;
        tick();
        tick();

        // Reset values
        check("rst_ack_m",  ack_m,  0);
        check("rst_err_m",  err_m,  0);
        check("rst_req_s",  req_s,  0);
        check("rst_we_s",   we_s,   0);
        check("rst_addr_s", addr_s, 0);
        check("rst_rd_sel", rd_sel, 4'b0001);
        resetn = 1'b1;
        tick();

        // Test 1: reset asserted mid-ACCESS aborts with no ack_m
        req_m = 1'b1; we_m = 1'b1; addr_m = 32'h0003_0020;
        tick();
        check("t1_req_s_access", req_s,  4'b1000);
        check("t1_we_s_access",  we_s,   1);
        check("t1_rd_sel_access", rd_sel, 4'b1000);
        req_m  = 1'b0;
        resetn = 1'b0;
        #1;
        check("t1_req_s_rst",  req_s,  0);
        check("t1_we_s_rst",   we_s,   0);
        check("t1_addr_s_rst", addr_s, 0);
        check("t1_rd_sel_rst", rd_sel, 4'b0001);
        check("t1_ack_m_rst",  ack_m,  0);
        tick();
        resetn = 1'b1;
        ack_s  = 4'b1000;
        tick();
        check("t1_ack_m_after1", ack_m, 0);
        tick();
        check("t1_ack_m_after2", ack_m, 0);
        tick();
        check("t1_ack_m_after3", ack_m, 0);
        check("t1_req_s_after",  req_s, 0);
        ack_s = '0;

        // Test 2: lw to GPIO, ack arrives a couple of cycles later
        req_m = 1'b1; we_m = 1'b0; addr_m = 32'h0001_0004;
        tick();
        check("t2_req_s",  req_s,  4'b0010);
        check("t2_we_s",   we_s,   0);
        check("t2_addr_s", addr_s, 32'h0001_0004);
        check("t2_rd_sel", rd_sel, 4'b0010);
        req_m = 1'b0;
        tick();
        check("t2_req_s_hold", req_s, 4'b0010);
        check("t2_ack_m_wait", ack_m, 0);
        ack_s = 4'b0010;
        tick();
        check("t2_req_s_drop", req_s, 0);
        check("t2_ack_m_early", ack_m, 0);
        ack_s = '0;
        tick();
        check("t2_ack_m", ack_m, 1);
        check("t2_err_m", err_m, 0);
        check("t2_rd_sel_resp", rd_sel, 4'b0010);
        tick();
        check("t2_ack_m_pulse", ack_m, 0);

        // Test 4: unmapped lw -> error pulse, rd_sel stays on GPIO
        req_m = 1'b1; we_m = 1'b0; addr_m = 32'h0005_0000;
        tick();
        check("t4_req_s",  req_s, 0);
        check("t4_ack_m0", ack_m, 0);
        req_m = 1'b0;
        tick();
        check("t4_ack_m",  ack_m,  1);
        check("t4_err_m",  err_m,  1);
        check("t4_rd_sel", rd_sel, 4'b0010);
        tick();
        check("t4_ack_m_pulse", ack_m, 0);
        check("t4_err_m_pulse", err_m, 0);

        // Test 3: sw to RAM acked immediately, back-to-back with req_m held high
        req_m = 1'b1; we_m = 1'b1; addr_m = 32'h0000_1000; ack_s = 4'b0001;
        tick();
        check("t3_req_s",  req_s,  4'b0001);
        check("t3_we_s",   we_s,   1);
        check("t3_rd_sel", rd_sel, 4'b0001);
        addr_m = 32'h0000_2000;
        tick();
        check("t3_addr_s_hold", addr_s, 32'h0000_1000);
        check("t3_ack_m_c2",    ack_m,  0);
        tick();
        check("t3_ack_m_c3", ack_m, 1);
        check("t3_err_m_c3", err_m, 0);
        tick();
        check("t3_ack_m_c4",   ack_m,  0);
        check("t3_req_s_2nd",  req_s,  4'b0001);
        check("t3_addr_s_2nd", addr_s, 32'h0000_2000);
        req_m = 1'b0;
        tick();
        check("t3_ack_m_c5", ack_m, 0);
        tick();
        check("t3_ack_m_c6", ack_m, 1);
        ack_s = '0;
        tick();
        check("t3_ack_m_c7", ack_m, 0);

        // Test 5: sw to PWM, no ack -> timeout after 15 cycles, then RAM access succeeds
        req_m = 1'b1; we_m = 1'b1; addr_m = 32'h0002_0000;
        tick();
        check("t5_req_s",  req_s,  4'b0100);
        check("t5_rd_sel", rd_sel, 4'b0100);
        req_m = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("t5_req_s_c15", req_s, 4'b0100);
        check("t5_ack_m_c15", ack_m, 0);
        tick();
        check("t5_req_s_drop", req_s, 0);
        check("t5_ack_m_drop", ack_m, 0);
        tick();
        check("t5_ack_m",  ack_m,  1);
        check("t5_err_m",  err_m,  1);
        check("t5_rd_sel_keep", rd_sel, 4'b0100);
        tick();
        check("t5_ack_m_pulse", ack_m, 0);
        req_m = 1'b1; we_m = 1'b0; addr_m = 32'h0000_0040; ack_s = 4'b0001;
        tick();
        check("t5_ram_req_s", req_s, 4'b0001);
        req_m = 1'b0;
        tick();
        tick();
        check("t5_ram_ack_m",  ack_m,  1);
        check("t5_ram_err_m",  err_m,  0);
        check("t5_ram_rd_sel", rd_sel, 4'b0001);
        ack_s = '0;
        tick();

        // Test 6: foreign ack and req_m toggling during UART access are ignored
        req_m = 1'b1; we_m = 1'b0; addr_m = 32'h0003_0010;
        tick();
        check("t6_req_s", req_s, 4'b1000);
        req_m = 1'b0; ack_s = 4'b0001;
        tick();
        check("t6_req_s_foreign", req_s, 4'b1000);
        req_m = 1'b1; addr_m = 32'h0000_0000;
        tick();
        check("t6_req_s_toggle", req_s,  4'b1000);
        check("t6_addr_s_hold",  addr_s, 32'h0003_0010);
        check("t6_ack_m_none",   ack_m,  0);
        req_m = 1'b0; ack_s = 4'b1000;
        tick();
        check("t6_req_s_drop", req_s, 0);
        ack_s = '0;
        tick();
        check("t6_ack_m",  ack_m,  1);
        check("t6_err_m",  err_m,  0);
        check("t6_rd_sel", rd_sel, 4'b1000);
        tick();
        check("t6_ack_m_pulse", ack_m, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
